// File: rtl/fft_bitrev_reorder_pkg.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder_pkg
// Shared FFT definitions used by the output reorder stage:
//   - bitrev()    : reverses the low 'w' bits of an index (w <= MAX_LOG2N)
//   - rd_state_t  : read-side FSM encoding (IDLE=0, READ=1)
//   - RAM_LAT     : read latency of the reorder RAM (output register on)
// ---------------------------------------------------------------------------
package fft_bitrev_reorder_pkg;

    localparam int unsigned MAX_LOG2N = 12;
    localparam int unsigned RAM_LAT   = 2;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Full-width reversal, then shift the reversed field down so only the
    // low 'w' bits of the argument are mirrored into the low 'w' result bits.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                    input int unsigned          w);
        logic [MAX_LOG2N-1:0] r;
        r = {<<{v}};
        return r >> (MAX_LOG2N - w);
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// ---------------------------------------------------------------------------
// xilinx_simple_dual_port_2_clock_ram
// Simple dual-port block RAM, one write port (A) and one read port (B).
//   clka/wea/addra/dina : write port
//   clkb/enb/addrb      : read port, read-first
//   rstb/regceb         : synchronous reset / clock enable of the B output
//                         register (HIGH_PERFORMANCE only)
//   doutb               : read data; 1 cycle after enb (LOW_LATENCY) or
//                         2 cycles (HIGH_PERFORMANCE)
// Contents are never reset.
// ---------------------------------------------------------------------------
module xilinx_simple_dual_port_2_clock_ram #(
    parameter int unsigned RAM_WIDTH       = 32,
    parameter int unsigned RAM_DEPTH       = 1024,
    parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         clkb,
    input  logic                         wea,
    input  logic                         enb,
    input  logic                         rstb,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clka) begin
        if (wea)
            bram[addra] <= dina;
    end

    always_ff @(posedge clkb) begin
        if (enb)
            ram_data <= bram[addrb];
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_outreg
            assign doutb = ram_data;
        end else begin : g_outreg
            always_ff @(posedge clkb) begin
                if (rstb)
                    doutb <= '0;
                else if (regceb)
                    doutb <= ram_data;
            end
        end
    endgenerate

endmodule

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
// Output reorder stage after the last R22SDF butterfly. Samples arrive in
// bit-reversed index order; each is written to a ping-pong RAM (2 banks of N)
// at its bit-reversed address, and completed banks are read out in natural
// order with an index tag. Single clock, no input back-pressure.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   din_valid/din_sof/din : input sample stream (bit-reversed order)
//   dout_valid/dout/dout_idx : natural-order output and its index
//   frame_err       : one-cycle pulse on resync, unsynced drop or overflow
//   busy            : a partial or pending frame is held
//   dout_sof/dout_eof : first/last sample markers (only with
//                       FFT_REORDER_MARK_EN defined)
// ---------------------------------------------------------------------------
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int unsigned LOG2N  = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic              din_sof,
    input  logic [DATA_W-1:0] din,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout,
    output logic [LOG2N-1:0]  dout_idx,
    output logic              frame_err,
    output logic              busy
`ifdef FFT_REORDER_MARK_EN
    ,
    output logic              dout_sof,
    output logic              dout_eof
`endif
);

    localparam int unsigned      N    = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    // write side
    logic [LOG2N-1:0] wr_cnt;
    logic             wr_bank;
    logic             synced;
    logic             wr_en;
    logic             wr_done;
    logic [LOG2N-1:0] wr_idx;
    logic [LOG2N:0]   wr_addr;

    // read side
    rd_state_t        rd_state;
    logic             rd_bank;
    logic [LOG2N-1:0] rd_cnt;
    logic             rd_issue;
    logic             rd_done;
    logic [LOG2N:0]   rd_addr;
    logic [1:0]       ready_cnt;
    logic             frame_accept;

    logic [RAM_LAT-1:0] v_pipe;
    logic [LOG2N-1:0]   idx_pipe [RAM_LAT];
    logic [DATA_W-1:0]  ram_dout;

    assign wr_en   = din_valid & (din_sof | synced);
    assign wr_idx  = din_sof ? '0 : wr_cnt;
    // sof always lands at index 0, so it can never complete a frame (N >= 4)
    assign wr_done = din_valid & ~din_sof & synced & (wr_cnt == LAST);
    assign wr_addr = {wr_bank, LOG2N'(bitrev(MAX_LOG2N'(wr_idx), LOG2N))};

    assign rd_issue = (rd_state == RD_READ);
    assign rd_done  = rd_issue & (rd_cnt == LAST);
    assign rd_addr  = {rd_bank, rd_cnt};

    // A completing frame is refused only if both banks are already full and
    // neither is being released on this same edge.
    assign frame_accept = wr_done & ~((ready_cnt == 2'd2) & ~rd_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            synced    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (din_valid) begin
                if (din_sof) begin
                    synced <= 1'b1;
                    wr_cnt <= LOG2N'(1);
                    if (wr_cnt != '0)
                        frame_err <= 1'b1;
                end else if (!synced) begin
                    frame_err <= 1'b1;
                end else if (wr_cnt == LAST) begin
                    wr_cnt <= '0;
                    if (frame_accept)
                        wr_bank <= ~wr_bank;
                    else
                        frame_err <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_cnt <= '0;
            rd_state  <= RD_IDLE;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            v_pipe    <= '0;
            for (int unsigned i = 0; i < RAM_LAT; i++)
                idx_pipe[i] <= '0;
`ifdef FFT_REORDER_MARK_EN
            dout_sof  <= 1'b0;
            dout_eof  <= 1'b0;
`endif
        end else begin
            if (frame_accept && !rd_done)
                ready_cnt <= ready_cnt + 2'd1;
            else if (!frame_accept && rd_done)
                ready_cnt <= ready_cnt - 2'd1;

            // rd_bank already points at the oldest full bank whenever idle
            case (rd_state)
                RD_IDLE: begin
                    if (ready_cnt != '0) begin
                        rd_state <= RD_READ;
                        rd_cnt   <= '0;
                    end
                end
                RD_READ: begin
                    if (rd_cnt == LAST) begin
                        rd_cnt  <= '0;
                        rd_bank <= ~rd_bank;
                        if (!((ready_cnt > 2'd1) || frame_accept))
                            rd_state <= RD_IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase

            v_pipe      <= {v_pipe[RAM_LAT-2:0], rd_issue};
            idx_pipe[0] <= rd_cnt;
            for (int unsigned i = 1; i < RAM_LAT; i++)
                idx_pipe[i] <= idx_pipe[i-1];

`ifdef FFT_REORDER_MARK_EN
            dout_sof <= v_pipe[RAM_LAT-2] & (idx_pipe[RAM_LAT-2] == '0);
            dout_eof <= v_pipe[RAM_LAT-2] & (idx_pipe[RAM_LAT-2] == LAST);
`endif
        end
    end

    xilinx_simple_dual_port_2_clock_ram #(
        .RAM_WIDTH       (DATA_W),
        .RAM_DEPTH       (2 * N),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_ram (
        .addra  (wr_addr),
        .addrb  (rd_addr),
        .dina   (din),
        .clka   (clk),
        .clkb   (clk),
        .wea    (wr_en),
        .enb    (rd_issue),
        .rstb   (rst),
        .regceb (1'b1),
        .doutb  (ram_dout)
    );

    assign dout_valid = v_pipe[RAM_LAT-1];
    assign dout_idx   = idx_pipe[RAM_LAT-1];
    // RAM output register resets synchronously; gating keeps dout at zero
    // from the moment the asynchronous reset asserts.
    assign dout       = dout_valid ? ram_dout : '0;

    assign busy = (synced & (wr_cnt != '0)) | (ready_cnt != '0) |
                  (rd_state == RD_READ) | (|v_pipe);

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

    localparam int LOG2N  = 3;
    localparam int N      = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              din_valid = 1'b0;
    logic              din_sof = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              dout_valid;
    logic [DATA_W-1:0] dout;
    logic [LOG2N-1:0]  dout_idx;
    logic              frame_err;
    logic              busy;
`ifdef FFT_REORDER_MARK_EN
    logic              dout_sof;
    logic              dout_eof;
`endif

    fft_bitrev_reorder #(.LOG2N(LOG2N), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din        (din),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_idx   (dout_idx),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef FFT_REORDER_MARK_EN
        ,
        .dout_sof   (dout_sof),
        .dout_eof   (dout_eof)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [LOG2N-1:0]  idx;
    } exp_t;

    exp_t sb[$];
    int   bursts[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   err_cnt = 0;
    int   run_len = 0;
    bit   prev_valid = 1'b0;
    int unsigned last_start_cyc = 0;

    // position j of a bit-reversed frame carries natural index tbl[j]
    int tbl [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    // output monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (frame_err === 1'b1) err_cnt++;
        if (dout_valid === 1'b1) begin
            run_len++;
            if (!prev_valid) last_start_cyc = cyc;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: dout_valid=1 idx=%0d dout=%h, required no output", dout_idx, dout);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (dout !== e.data || dout_idx !== e.idx) begin
                    n_fail++;
                    $display("FAIL sb_data: dout=%h idx=%0d, required dout=%h idx=%0d", dout, dout_idx, e.data, e.idx);
                end
`ifdef FFT_REORDER_MARK_EN
                n_checks++;
                if (dout_sof !== (e.idx == 0) || dout_eof !== (e.idx == LOG2N'(N-1))) begin
                    n_fail++;
                    $display("FAIL marks: sof=%b eof=%b at idx %0d, required sof=%b eof=%b",
                             dout_sof, dout_eof, e.idx, (e.idx == 0), (e.idx == LOG2N'(N-1)));
                end
`endif
            end
        end else begin
            if (prev_valid) begin
                bursts.push_back(run_len);
                run_len = 0;
            end
`ifdef FFT_REORDER_MARK_EN
            n_checks++;
            if (dout_sof !== 1'b0 || dout_eof !== 1'b0) begin
                n_fail++;
                $display("FAIL marks_idle: sof=%b eof=%b, required 0 0", dout_sof, dout_eof);
            end
`endif
        end
        prev_valid = (dout_valid === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    task automatic idle();
        @(negedge clk);
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    // drives one full frame in bit-reversed order; gap inserts an idle cycle
    // after every sample; expected natural-order results go to the scoreboard
    task automatic send_frame(input int unsigned base, input bit gap);
        for (int j = 0; j < N; j++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din_sof   = (j == 0);
            din       = DATA_W'(base + tbl[j]);
            if (gap) idle();
        end
        for (int k = 0; k < N; k++)
            sb.push_back('{data: DATA_W'(base + k), idx: LOG2N'(k)});
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && sb.size() == 0) break;
        end
        @(negedge clk);
        n_checks++;
        if (i == 300) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%b pending=%0d, required idle with nothing pending", busy, sb.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        din_sof = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        bursts.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b, required 0", dout_valid); end
        n_checks++;
        if (dout_idx !== '0) begin n_fail++; $display("FAIL reset_dout_idx: got %0d, required 0", dout_idx); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++;
        if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h, required 0", dout); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b dout_valid=%b, required 0 0", busy, dout_valid);
        end
    endtask

    task automatic test_single();
        int unsigned e_last;
        int e0;
        e0 = err_cnt;
        bursts.delete();
        send_frame(0, 1'b0);
        e_last = cyc + 1;
        idle();
        wait_drain();
        n_checks++;
        if (last_start_cyc - e_last !== 3) begin
            n_fail++;
            $display("FAIL single_latency: first valid %0d edges after last write, required 3", last_start_cyc - e_last);
        end
        n_checks++;
        if (bursts.size() != 1 || bursts[0] != N) begin
            n_fail++;
            $display("FAIL single_burst: %0d bursts first len %0d, required 1 burst of %0d", bursts.size(), (bursts.size() > 0) ? bursts[0] : 0, N);
        end
        n_checks++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL single_err: %0d frame_err cycles, required 0", err_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        int e0;
        e0 = err_cnt;
        bursts.delete();
        send_frame(100, 1'b0);
        send_frame(200, 1'b0);
        send_frame(300, 1'b0);
        idle();
        wait_drain();
        n_checks++;
        if (bursts.size() != 1 || bursts[0] != 3 * N) begin
            n_fail++;
            $display("FAIL b2b_burst: %0d bursts first len %0d, required 1 burst of %0d", bursts.size(), (bursts.size() > 0) ? bursts[0] : 0, 3 * N);
        end
        n_checks++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL b2b_err: %0d frame_err cycles, required 0", err_cnt - e0); end
    endtask

    task automatic test_gapped();
        int e0;
        e0 = err_cnt;
        bursts.delete();
        send_frame(1000, 1'b1);
        send_frame(2000, 1'b1);
        wait_drain();
        n_checks++;
        if (bursts.size() != 2 || bursts[0] != N || bursts[1] != N) begin
            n_fail++;
            $display("FAIL gapped_bursts: %0d bursts, required 2 bursts of %0d", bursts.size(), N);
        end
        n_checks++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL gapped_err: %0d frame_err cycles, required 0", err_cnt - e0); end
    endtask

    task automatic test_resync();
        int e0;
        e0 = err_cnt;
        bursts.delete();
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din_sof   = (j == 0);
            din       = DATA_W'(5000 + j);
        end
        idle();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL partial_busy: got %b, required 1", busy); end
        send_frame(6000, 1'b0);
        idle();
        wait_drain();
        n_checks++;
        if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL resync_err: %0d frame_err cycles, required 1", err_cnt - e0); end
        n_checks++;
        if (bursts.size() != 1 || bursts[0] != N) begin
            n_fail++;
            $display("FAIL resync_burst: %0d bursts, required 1 burst of %0d", bursts.size(), N);
        end
    endtask

    task automatic test_reset_mid_read();
        int i;
        send_frame(7000, 1'b0);
        idle();
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dout_valid === 1'b1 && dout_idx === LOG2N'(1)) break;
        end
        n_checks++;
        if (i == 50) begin n_fail++; $display("FAIL midread_wait: dout_idx 1 never seen, required within 50 cycles"); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (dout_valid !== 1'b0 || dout_idx !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_reset: valid=%b idx=%0d busy=%b, required 0 0 0", dout_valid, dout_idx, busy);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bursts.delete();
        repeat (20) @(negedge clk);
        n_checks++;
        if (bursts.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_quiet: %0d bursts busy=%b, required 0 bursts busy 0", bursts.size(), busy);
        end
        send_frame(8000, 1'b0);
        idle();
        wait_drain();
        n_checks++;
        if (bursts.size() != 1 || bursts[0] != N) begin
            n_fail++;
            $display("FAIL midread_recover: %0d bursts, required 1 burst of %0d", bursts.size(), N);
        end
    endtask

    task automatic test_unsynced();
        int e0;
        do_reset();
        e0 = err_cnt;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din_sof   = 1'b0;
            din       = DATA_W'(9000 + j);
        end
        idle();
        repeat (20) @(negedge clk);
        n_checks++;
        if (err_cnt - e0 != 4) begin n_fail++; $display("FAIL unsynced_err: %0d frame_err cycles, required 4", err_cnt - e0); end
        n_checks++;
        if (bursts.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL unsynced_quiet: %0d bursts busy=%b, required 0 bursts busy 0", bursts.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gapped();
        test_resync();
        test_reset_mid_read();
        test_unsynced();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
